// File: rtl/divmod_pkg.sv
// ============================================================================
//  Module      : divmod_pkg
//  Description : Shared types and constants for the divmod_cu divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package divmod_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/divmod_step.sv
// ============================================================================
//  Module      : divmod_step
//  Description : One combinational restoring-division iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divmod_step
    import divmod_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] w_trial;

    // rem_in < divisor, so the shifted value fits in WIDTH+1 bits and the
    // top bit of the difference acts as the borrow.
    assign w_trial = {rem_in, dvd_bit} - {1'b0, divisor};
    assign q_bit   = ~w_trial[WIDTH];
    assign rem_out = q_bit ? w_trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], dvd_bit};

endmodule

`default_nettype wire

// File: rtl/divmod_cu.sv
// ============================================================================
//  Module      : divmod_cu
//  Description : Multi-cycle signed/unsigned restoring divider with modulo.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divmod_cu
    import divmod_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_done;
    logic             r_busy;
    logic             r_dbz;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem_nxt;
    logic             w_qbit;
    logic             w_b_zero;

    assign w_b_zero = (b == '0);
    assign w_abs_a  = (signed_op && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (signed_op && b[WIDTH-1]) ? -b : b;

    divmod_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (r_rem),
        .dvd_bit (r_dvd[WIDTH-1]),
        .divisor (r_dvs),
        .rem_out (w_rem_nxt),
        .q_bit   (w_qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = w_b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_next = FIX;
                end
            end
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // done trails the DONE state by one cycle; busy covers that cycle too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            r_busy <= (w_next != IDLE) || (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start && w_b_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= a;
                        r_dbz       <= 1'b1;
                    end else if (start) begin
                        r_dvd   <= w_abs_a;
                        r_dvs   <= w_abs_b;
                        r_rem   <= '0;
                        r_cnt   <= CW'(WIDTH);
                        r_neg_q <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= signed_op && a[WIDTH-1];
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt - CW'(1);
                end
                FIX: begin
                    r_quotient  <= r_neg_q ? -r_dvd : r_dvd;
                    r_remainder <= r_neg_r ? -r_rem : r_rem;
                    r_dbz       <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign done        = r_done;
    assign busy        = r_busy;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: doc/divmod_cu.md
DIVMOD_CU -- requirements
Module: divmod_cu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal 4..64).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; accepted only when state is IDLE.
REQ-005 signed_op  input  1  1 = two's-complement operation, 0 = unsigned; sampled with start.
REQ-006 a  input  WIDTH  dividend; sampled with start.
REQ-007 b  input  WIDTH  divisor; sampled with start.
REQ-008 quotient  output  WIDTH  registered quotient.
REQ-009 remainder  output  WIDTH  registered remainder (modulo result).
REQ-010 done  output  1  one-cycle pulse, results valid.
REQ-011 busy  output  1  high from accept until the cycle done is high, inclusive.
REQ-012 div_by_zero  output  1  registered flag for the last completed operation.

Function
REQ-013 States: IDLE, CALC, FIX, DONE. Operands, mode and counter are held in registers; outputs are registered.
REQ-014 IDLE: if start=1 and b!=0, latch |a|, |b|, the sign flags and signed_op, load counter=WIDTH, and go to CALC. Magnitudes are taken only when signed_op=1.
REQ-015 IDLE with start=1 and b=0: go directly to DONE with quotient=all ones, remainder=a, div_by_zero=1.
REQ-016 CALC: restoring shift-subtract, one quotient bit per cycle, MSB first; the counter decrements each cycle; at counter 1 go to FIX.
REQ-017 FIX: if signed, negate the quotient when the operand signs differ and negate the remainder when a<0. Write quotient/remainder, set div_by_zero=0, go to DONE.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE.
REQ-019 Latency: start accepted at edge k; done is high in the cycle after edge k+WIDTH+2. Divide-by-zero: done is high after edge k+1.
REQ-020 Signed semantics: the quotient truncates toward zero and the remainder takes the sign of the dividend. a=MIN, b=-1 gives quotient=MIN and remainder=0, with no flag.
REQ-021 Outputs hold their values from done until the next result write. They do not change during a later CALC.
REQ-022 start while busy=1 is ignored and is not queued. If start is held high, a new operation is accepted on the first IDLE cycle after DONE.
REQ-023 Changes on a, b or signed_op while busy=1 have no effect on the running operation.

Reset
REQ-024 rst=0 forces immediately: state=IDLE, counter=0, quotient=0, remainder=0, done=0, busy=0, div_by_zero=0.
REQ-025 Reset during CALC/FIX/DONE aborts the operation with no done pulse. The first edge after release with start=1 is accepted normally.

Structure
REQ-026 Package divmod_pkg holds the state enumeration and the default WIDTH constant.
REQ-027 One sub-module, divmod_step, holds one combinational restoring iteration: partial remainder and dividend bit in; new partial remainder and quotient bit out. divmod_cu instantiates it once.
REQ-028 Target size is 120-400 lines of RTL, with no multipliers or dividers inferred.

Verification
REQ-029 WIDTH=32, unsigned, a=10, b=4: quotient=2 and remainder=2, with done high 34 cycles after accept; done high exactly 1 cycle; busy high 35 cycles.
REQ-030 Unsigned a=87, b=6 gives quotient=14, remainder=3. Signed a=-7, b=2 gives quotient=-3, remainder=-1. Signed a=7, b=-2 gives quotient=-3, remainder=1.
REQ-031 a=5, b=0 gives done 1 cycle after accept, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. The next valid operation clears div_by_zero.
REQ-032 Start pulse at cycle 10 of a running operation with different a/b: ignored. The first result is unchanged and exactly one done pulse occurs.
REQ-033 rst low at cycle 15 of CALC: all outputs 0 and no done pulse. After release, a=100, b=7 gives quotient=14, remainder=2.
REQ-034 WIDTH=8 instance: unsigned 255/16 gives quotient=15, remainder=15, done after 10 cycles. Signed -128/-1 gives quotient=-128, remainder=0.
